inst_rom_loader: RTL and testbench
==================================

Name: inst_rom_loader

Overview:
- Instruction ROM responder for the CPU core's fetch port: answers rom_ce/rom_addr with a combinational 32-bit instruction, as the IF/ID stage latches it in the same cycle.
- Contents are filled after every reset by a byte-stream boot loader with a valid/ready handshake.
- Holds the CPU in reset through cpu_rst_o until loading completes.
- Sits beside the core at SoC top level: its inst output drives the core's ROM data input, and cpu_rst_o drives the core's rst.

Parameters:
- ROM_AW, 10, word-address width; depth = 2**ROM_AW words.
- BIG_ENDIAN, 1, 1: first stream byte fills inst[31:24]; 0: first byte fills inst[7:0].

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset (one clock; reset is synchronous and active-high).
- ce  in  1  fetch chip enable from the core.
- addr  in  32  fetch byte address from the core (pc).
- inst  out  32  instruction word, combinational.
- load_valid_i  in  1  loader byte valid.
- load_byte_i  in  8  loader byte.
- load_last_i  in  1  marks the final byte of the image; qualified by valid&ready.
- load_ready_o  out  1  loader may transfer this cycle.
- cpu_rst_o  out  1  registered reset to the core.
- load_done_o  out  1  image loaded; ROM serving fetches.
- load_err_o  out  1  image overflowed ROM depth; sticky.
- words_loaded_o  out  ROM_AW+1  count of words written.

Behaviour:
- State machine: LOAD, RUN, ERR. rst -> LOAD (wins over any same-cycle handshake).
- Reset values: state = LOAD, word ptr = 0, byte cnt = 0, assembly reg = 0, cpu_rst_o = 1, load_done_o = 0, load_err_o = 0, words_loaded_o = 0, load_ready_o = 1 (combinational from state).
- Array contents are NOT cleared by reset. Stale words are hidden by the count check below.
- Accept = load_valid_i & load_ready_o. A valid without ready is ignored; the loader must hold the byte.
- load_ready_o = 1 only in LOAD.
- Byte packing:
  - byte cnt 0..3 selects the lane per BIG_ENDIAN.
  - On accept with cnt = 3, the full word (new byte merged) is written to mem[ptr] at that edge; then ptr++, cnt = 0, assembly reg cleared.
- load_last_i on an accepted byte:
  - The current word is written at that edge even if partial. Unfilled lanes are zero.
  - ptr++; state -> RUN.
  - Example (BIG_ENDIAN=1): 2 bytes AA, BB with last on BB -> word 0xAABB0000.
- Overflow: an accept while ptr == 2**ROM_AW -> no write, state -> ERR, load_err_o = 1. Stays in ERR until rst; cpu_rst_o stays 1.
- In RUN:
  - cpu_rst_o = 0 and load_done_o = 1, both registered. They change at the edge after the edge that enters RUN, so the core sees its first non-reset cycle 2 cycles after the last byte is accepted.
  - No further writes; loader inputs are ignored.
- words_loaded_o = ptr (saturates at 2**ROM_AW).
- Fetch read, combinational:
  - inst = 0 if ce = 0, state != RUN, addr[31:ROM_AW+2] != 0, or addr[ROM_AW+1:2] >= ptr.
  - Otherwise inst = mem[addr[ROM_AW+1:2]].
  - addr[1:0] is ignored (word-aligned fetch).
- Reset mid-load: state returns to LOAD, ptr = 0. Previously written words become unreadable until rewritten.
- Reset while in RUN: cpu_rst_o = 1 at the next edge, and a full reload is required.
- Zero-length image is not possible: load_last_i always carries a byte.

Decomposition:
- Shared defines header: InstAddrBus, InstBus, ZeroWord, ChipEnable/ChipDisable (existing), plus new ROM_AW default and the LOAD/RUN/ERR state encodings.
- One natural sub-module: byte_packer. It holds the byte cnt, lane select and zero-padding, and emits word + word_valid on the 4th byte or on last.
- The FSM, pointer, array and read mux stay in inst_rom_loader.

Test Plan:
- Basic load (BIG_ENDIAN=1, ROM_AW=10): stream 34 01 00 05, then 00 00 00 00 with last on the final byte -> words_loaded_o = 2. cpu_rst_o falls 2 cycles after the last accept; addr 0x0 -> inst 0x34010005, addr 0x4 -> 0x00000000, addr 0x8 -> 0 (beyond count).
- Partial word + backpressure gaps: bytes AA BB C0 DE 11 with last on 11, valid deasserted between bytes -> mem[0] = 0xAABBC0DE, mem[1] = 0x11000000, words_loaded_o = 2; BIG_ENDIAN=0 gives mem[0] = 0xDEC0BBAA, mem[1] = 0x00000011.
- Fetch gating after load: ce = 0 -> inst = 0; addr = 0x00001000 (above depth) -> 0; addr = 0x3 -> same as addr 0; during LOAD any addr -> 0.
- Overflow (ROM_AW=2): stream 17 bytes without last -> after the 16th byte words_loaded_o = 4; the 17th accept sets load_err_o = 1, load_ready_o = 0, cpu_rst_o stays 1; further valids are ignored.
- Reset mid-load: load 8 bytes, pulse rst for 1 cycle, then load 4 bytes 12 34 56 78 with last -> words_loaded_o = 1, addr 0x4 -> 0 (stale word hidden), addr 0x0 -> 0x12345678.
- Reset from RUN and reload: after a completed load, pulse rst -> cpu_rst_o = 1 and load_done_o = 0 the next cycle; load_ready_o = 1; the new image replaces the old.

Source files
------------

// File: rtl/inst_rom_loader_pkg.sv
// Shared definitions for the instruction ROM loader: bus widths, constants,
// loader state encoding and a byte-lane placement helper.
package inst_rom_loader_pkg;

    localparam int unsigned InstAddrBus  = 32;
    localparam int unsigned InstBus      = 32;
    localparam logic [31:0] ZeroWord     = 32'h0000_0000;
    localparam logic        ChipEnable   = 1'b1;
    localparam logic        ChipDisable  = 1'b0;
    localparam int unsigned RomAwDefault = 10;

    typedef enum logic [1:0] {
        StLoad = 2'd0,
        StRun  = 2'd1,
        StErr  = 2'd2
    } loader_state_e;

    // Place a byte into the given lane of a 32-bit word, other lanes zero.
    function automatic logic [31:0] place_byte(input logic [7:0] b, input logic [1:0] lane);
        return {24'h00_0000, b} << {lane, 3'b000};
    endfunction

endpackage

// File: rtl/inst_rom_loader_byte_packer.sv
// Assembles loader bytes into 32-bit words. Emits a word on the fourth byte or
// on the byte flagged last; lanes not yet filled stay zero.
module inst_rom_loader_byte_packer
    import inst_rom_loader_pkg::*;
#(
    parameter bit BIG_ENDIAN = 1'b1
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_accept,
    input  logic [7:0]  i_byte,
    input  logic        i_last,
    output logic [31:0] o_word,
    output logic        o_word_valid
);

    logic [1:0]  r_cnt;
    logic [31:0] r_asm;
    logic [1:0]  w_lane;
    logic [31:0] w_merged;

    // Lane select and merge of the incoming byte into the partial word.
    always_comb begin
        w_lane       = BIG_ENDIAN ? ~r_cnt : r_cnt;
        w_merged     = r_asm | place_byte(i_byte, w_lane);
        o_word       = w_merged;
        o_word_valid = i_accept & ((r_cnt == 2'd3) | i_last);
    end

    // Byte counter and assembly register; cleared whenever a word is emitted.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt <= 2'd0;
            r_asm <= ZeroWord;
        end else if (i_accept) begin
            if (o_word_valid) begin
                r_cnt <= 2'd0;
                r_asm <= ZeroWord;
            end else begin
                r_cnt <= r_cnt + 2'd1;
                r_asm <= w_merged;
            end
        end
    end

endmodule

// File: rtl/inst_rom_loader.sv
// Instruction ROM with a byte-stream boot loader. Holds the core in reset
// until an image has been streamed in, then serves combinational fetches.
module inst_rom_loader
    import inst_rom_loader_pkg::*;
#(
    parameter int unsigned ROM_AW     = RomAwDefault,
    parameter bit          BIG_ENDIAN = 1'b1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   ce,
    input  logic [InstAddrBus-1:0] addr,
    output logic [InstBus-1:0]     inst,
    input  logic                   load_valid_i,
    input  logic [7:0]             load_byte_i,
    input  logic                   load_last_i,
    output logic                   load_ready_o,
    output logic                   cpu_rst_o,
    output logic                   load_done_o,
    output logic                   load_err_o,
    output logic [ROM_AW:0]        words_loaded_o
);

    localparam int unsigned Depth = 2 ** ROM_AW;

    loader_state_e        r_state;
    loader_state_e        w_state_d;
    logic [ROM_AW:0]      r_ptr;
    logic                 r_cpu_rst;
    logic                 r_done;
    logic                 r_err;
    logic [InstBus-1:0]   r_mem [Depth];

    logic                 w_accept;
    logic                 w_full;
    logic                 w_overflow;
    logic                 w_pack_accept;
    logic [InstBus-1:0]   w_word;
    logic                 w_word_valid;
    logic [ROM_AW-1:0]    w_idx;
    logic                 w_hi_ok;
    logic [1:0]           w_unused_addr;

    assign load_ready_o   = (r_state == StLoad);
    assign w_accept       = load_valid_i & load_ready_o;
    // Pointer never exceeds Depth, so its MSB alone marks a full ROM.
    assign w_full         = r_ptr[ROM_AW];
    assign w_overflow     = w_accept & w_full;
    assign w_pack_accept  = w_accept & ~w_full;
    assign cpu_rst_o      = r_cpu_rst;
    assign load_done_o    = r_done;
    assign load_err_o     = r_err;
    assign words_loaded_o = r_ptr;
    assign w_unused_addr  = addr[1:0];

    inst_rom_loader_byte_packer #(
        .BIG_ENDIAN (BIG_ENDIAN)
    ) u_packer (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_accept     (w_pack_accept),
        .i_byte       (load_byte_i),
        .i_last       (load_last_i),
        .o_word       (w_word),
        .o_word_valid (w_word_valid)
    );

    // Loader state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= StLoad;
        end else begin
            r_state <= w_state_d;
        end
    end

    // Next-state logic: overflow takes priority over a last byte.
    always_comb begin
        w_state_d = r_state;
        unique case (r_state)
            StLoad: begin
                if (w_overflow) begin
                    w_state_d = StErr;
                end else if (w_pack_accept && load_last_i) begin
                    w_state_d = StRun;
                end
            end
            StRun:   w_state_d = StRun;
            StErr:   w_state_d = StErr;
            default: w_state_d = StLoad;
        endcase
    end

    // Word pointer and registered status; core reset releases one edge after RUN.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr     <= '0;
            r_cpu_rst <= 1'b1;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            if (w_word_valid) begin
                r_ptr <= r_ptr + 1'b1;
            end
            if (w_overflow) begin
                r_err <= 1'b1;
            end
            r_cpu_rst <= (r_state != StRun);
            r_done    <= (r_state == StRun);
        end
    end

    // ROM array write; contents survive reset and are hidden by the pointer.
    always_ff @(posedge clk) begin
        if (!rst && w_word_valid) begin
            r_mem[r_ptr[ROM_AW-1:0]] <= w_word;
        end
    end

    // Combinational fetch; only words below the pointer are visible, and only in RUN.
    always_comb begin
        w_idx   = addr[ROM_AW+1:2];
        w_hi_ok = (addr[InstAddrBus-1:ROM_AW+2] == '0);
        inst    = ZeroWord;
        if ((ce == ChipEnable) && (r_state == StRun) && w_hi_ok && ({1'b0, w_idx} < r_ptr)) begin
            inst = r_mem[w_idx];
        end
    end

endmodule

// File: tb/tb_inst_rom_loader.sv
// Directed bench for inst_rom_loader. Three instances share one stimulus:
// big-endian and little-endian with ROM_AW=10, and big-endian with ROM_AW=2.
module tb_inst_rom_loader;

    logic        clk;
    logic        rst;
    logic        ce;
    logic [31:0] addr;
    logic        load_valid;
    logic [7:0]  load_byte;
    logic        load_last;

    logic [31:0] inst_a, inst_b, inst_c;
    logic        ready_a, ready_b, ready_c;
    logic        cpu_rst_a, cpu_rst_b, cpu_rst_c;
    logic        done_a, done_b, done_c;
    logic        err_a, err_b, err_c;
    logic [10:0] words_a, words_b;
    logic [2:0]  words_c;

    int checks   = 0;
    int failures = 0;

    inst_rom_loader #(.ROM_AW(10), .BIG_ENDIAN(1'b1)) dut_a (
        .clk(clk), .rst(rst), .ce(ce), .addr(addr), .inst(inst_a),
        .load_valid_i(load_valid), .load_byte_i(load_byte), .load_last_i(load_last),
        .load_ready_o(ready_a), .cpu_rst_o(cpu_rst_a), .load_done_o(done_a),
        .load_err_o(err_a), .words_loaded_o(words_a)
    );

    inst_rom_loader #(.ROM_AW(10), .BIG_ENDIAN(1'b0)) dut_b (
        .clk(clk), .rst(rst), .ce(ce), .addr(addr), .inst(inst_b),
        .load_valid_i(load_valid), .load_byte_i(load_byte), .load_last_i(load_last),
        .load_ready_o(ready_b), .cpu_rst_o(cpu_rst_b), .load_done_o(done_b),
        .load_err_o(err_b), .words_loaded_o(words_b)
    );

    inst_rom_loader #(.ROM_AW(2), .BIG_ENDIAN(1'b1)) dut_c (
        .clk(clk), .rst(rst), .ce(ce), .addr(addr), .inst(inst_c),
        .load_valid_i(load_valid), .load_byte_i(load_byte), .load_last_i(load_last),
        .load_ready_o(ready_c), .cpu_rst_o(cpu_rst_c), .load_done_o(done_c),
        .load_err_o(err_c), .words_loaded_o(words_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One byte offered for exactly one clock, then valid drops.
    task automatic send(input logic [7:0] b, input logic last);
        load_valid = 1'b1;
        load_byte  = b;
        load_last  = last;
        tick(1);
        load_valid = 1'b0;
        load_last  = 1'b0;
        load_byte  = 8'h00;
    endtask

    task automatic pulse_rst();
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
    endtask

    initial begin
        rst        = 1'b1;
        ce         = 1'b1;
        addr       = 32'h0;
        load_valid = 1'b0;
        load_byte  = 8'h00;
        load_last  = 1'b0;
        tick(2);
        rst = 1'b0;

        // Reset state
        check("rst_cpu_rst", {31'b0, cpu_rst_a}, 32'd1);
        check("rst_done",    {31'b0, done_a},    32'd0);
        check("rst_err",     {31'b0, err_a},     32'd0);
        check("rst_ready",   {31'b0, ready_a},   32'd1);
        check("rst_words",   {21'b0, words_a},   32'd0);
        check("rst_inst",    inst_a,             32'h0);

        // Basic load: 34 01 00 05 | 00 00 00 00(last)
        send(8'h34, 1'b0); send(8'h01, 1'b0); send(8'h00, 1'b0); send(8'h05, 1'b0);
        check("load_words_mid", {21'b0, words_a}, 32'd1);
        check("load_inst_hidden", inst_a, 32'h0);
        send(8'h00, 1'b0); send(8'h00, 1'b0); send(8'h00, 1'b0); send(8'h00, 1'b1);
        check("last_words_a",   {21'b0, words_a},   32'd2);
        check("last_words_c",   {29'b0, words_c},   32'd2);
        check("last_cpu_rst",   {31'b0, cpu_rst_a}, 32'd1);
        check("last_done",      {31'b0, done_a},    32'd0);
        check("last_ready",     {31'b0, ready_a},   32'd0);
        tick(1);
        check("run_cpu_rst",    {31'b0, cpu_rst_a}, 32'd0);
        check("run_done",       {31'b0, done_a},    32'd1);
        check("run_ready_ign",  {31'b0, ready_b},   32'd0);
        addr = 32'h0; #1;
        check("fetch0_be",  inst_a, 32'h3401_0005);
        check("fetch0_le",  inst_b, 32'h0500_0134);
        check("fetch0_aw2", inst_c, 32'h3401_0005);
        addr = 32'h4; #1;
        check("fetch4_be",  inst_a, 32'h0);
        addr = 32'h8; #1;
        check("fetch8_beyond", inst_a, 32'h0);
        addr = 32'h3; #1;
        check("fetch3_align", inst_a, 32'h3401_0005);
        addr = 32'h0000_1000; #1;
        check("fetch_hi_a", inst_a, 32'h0);
        check("fetch_hi_c", inst_c, 32'h0);
        addr = 32'h0; ce = 1'b0; #1;
        check("fetch_ce0", inst_a, 32'h0);
        ce = 1'b1;

        // Reset from RUN, then partial word with idle gaps between bytes
        pulse_rst();
        check("rerst_cpu_rst", {31'b0, cpu_rst_a}, 32'd1);
        check("rerst_done",    {31'b0, done_a},    32'd0);
        check("rerst_ready",   {31'b0, ready_a},   32'd1);
        check("rerst_words",   {21'b0, words_a},   32'd0);
        check("rerst_inst",    inst_a,             32'h0);
        send(8'hAA, 1'b0); tick(1);
        send(8'hBB, 1'b0); tick(2);
        send(8'hC0, 1'b0); tick(1);
        send(8'hDE, 1'b0); tick(1);
        send(8'h11, 1'b1);
        tick(1);
        check("gap_words", {21'b0, words_a}, 32'd2);
        check("gap_done",  {31'b0, done_b},  32'd1);
        addr = 32'h0; #1;
        check("gap_m0_be", inst_a, 32'hAABB_C0DE);
        check("gap_m0_le", inst_b, 32'hDEC0_BBAA);
        addr = 32'h4; #1;
        check("gap_m1_be", inst_a, 32'h1100_0000);
        check("gap_m1_le", inst_b, 32'h0000_0011);

        // Reset mid-load: stale words must be hidden after reload
        pulse_rst();
        for (int i = 1; i <= 8; i++) send(8'(i), 1'b0);
        check("mid_words", {21'b0, words_a}, 32'd2);
        pulse_rst();
        check("mid_rst_words", {21'b0, words_a}, 32'd0);
        send(8'h12, 1'b0); send(8'h34, 1'b0); send(8'h56, 1'b0); send(8'h78, 1'b1);
        tick(1);
        check("mid_reload_words", {21'b0, words_a}, 32'd1);
        addr = 32'h4; #1;
        check("mid_stale_hidden", inst_a, 32'h0);
        addr = 32'h0; #1;
        check("mid_m0_be", inst_a, 32'h1234_5678);
        check("mid_m0_le", inst_b, 32'h7856_3412);

        // Overflow on the 4-word ROM
        pulse_rst();
        for (int i = 0; i < 16; i++) send(8'(i), 1'b0);
        check("ovf_words16", {29'b0, words_c}, 32'd4);
        check("ovf_err16",   {31'b0, err_c},   32'd0);
        check("ovf_ready16", {31'b0, ready_c}, 32'd1);
        send(8'h10, 1'b0);
        check("ovf_err",     {31'b0, err_c},     32'd1);
        check("ovf_ready",   {31'b0, ready_c},   32'd0);
        check("ovf_cpu_rst", {31'b0, cpu_rst_c}, 32'd1);
        check("ovf_words",   {29'b0, words_c},   32'd4);
        send(8'hFF, 1'b1);
        tick(2);
        check("ovf_hold_err",   {31'b0, err_c},     32'd1);
        check("ovf_hold_rst",   {31'b0, cpu_rst_c}, 32'd1);
        check("ovf_hold_done",  {31'b0, done_c},    32'd0);
        check("ovf_hold_words", {29'b0, words_c},   32'd4);
        check("big_words",      {21'b0, words_a},   32'd5);
        check("big_cpu_rst",    {31'b0, cpu_rst_a}, 32'd0);
        check("big_err",        {31'b0, err_a},     32'd0);
        addr = 32'h10; #1;
        check("big_m4_be", inst_a, 32'h10FF_0000);
        check("big_m4_le", inst_b, 32'h0000_FF10);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
